// File: rtl/backup_restore_ctrl_if.sv
// Handshake bundle between the backup/restore controller and the wrapped registers + NVM.
// master = controller side, slave = register wrappers / NVM side.
interface backup_restore_ctrl_if #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ADDR_W   = 4
);
  logic                      Bkp_req;
  logic                      Rstr_req;
  logic [NUM_REGS-1:0]       Dirty_val;
  logic [NUM_REGS-1:0]       Backup_en;
  logic [NUM_REGS-1:0]       Backup_ack;
  logic [NUM_REGS*WIDTH-1:0] Backup_Vout;
  logic [NUM_REGS-1:0]       Rst_DrtyCtrl;
  logic [NUM_REGS-1:0]       Restore_en;
  logic [WIDTH-1:0]          Restore_Vin;
  logic                      nvm_wr_en;
  logic                      nvm_rd_en;
  logic [ADDR_W-1:0]         nvm_addr;
  logic [WIDTH-1:0]          nvm_wdata;
  logic [WIDTH-1:0]          nvm_rdata;
  logic                      nvm_ack;
  logic                      stand_by;
  logic                      Done;
  logic                      Rstr_fail;

  modport master (
    input  Bkp_req, Rstr_req, Dirty_val, Backup_ack, Backup_Vout, nvm_rdata, nvm_ack,
    output Backup_en, Rst_DrtyCtrl, Restore_en, Restore_Vin, nvm_wr_en, nvm_rd_en, nvm_addr,
           nvm_wdata, stand_by, Done, Rstr_fail
  );

  modport slave (
    output Bkp_req, Rstr_req, Dirty_val, Backup_ack, Backup_Vout, nvm_rdata, nvm_ack,
    input  Backup_en, Rst_DrtyCtrl, Restore_en, Restore_Vin, nvm_wr_en, nvm_rd_en, nvm_addr,
           nvm_wdata, stand_by, Done, Rstr_fail
  );
endinterface

// File: rtl/backup_restore_ctrl.sv
// Backup/restore initiator: copies dirty registers to NVM on power-fail and restores all
// registers from NVM on power-good, guarded by a checkpoint marker word.
module backup_restore_ctrl #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ADDR_W   = 4,
  parameter logic [31:0] MARKER   = 32'hA5A55A5A
) (
  input  logic                         Clk,
  input  logic                         Rst,
  backup_restore_ctrl_if.master        bus_io
);

  localparam logic [WIDTH-1:0]  MarkerW  = WIDTH'(MARKER);
  localparam logic [ADDR_W-1:0] MarkAddr = ADDR_W'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] IdxOne   = ADDR_W'(1);

  typedef enum logic [3:0] {
    StIdle, StBkInv, StBkScan, StBkReq, StBkWr, StBkMark, StRsChk, StRsRd, StRsWr, StDone
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [NUM_REGS-1:0] backup_en_q, rst_drty_q, restore_en_q;
  logic [WIDTH-1:0]    restore_vin_q, wdata_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                wr_en_q, rd_en_q, stand_by_q, done_q, fail_q;

  logic [NUM_REGS-1:0] idx_oh;
  logic [WIDTH-1:0]    vout_sel;
  logic                dirty_sel, ack_sel;

  // idx_oh is all-zero once idx reaches NUM_REGS, so dirty/ack selection is safe there
  always_comb begin
    idx_oh    = NUM_REGS'(1) << idx_q;
    vout_sel  = WIDTH'(bus_io.Backup_Vout >> (32'(idx_q) * WIDTH));
    dirty_sel = |(bus_io.Dirty_val & idx_oh);
    ack_sel   = |(bus_io.Backup_ack & idx_oh);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      backup_en_q   <= '0;
      rst_drty_q    <= '0;
      restore_en_q  <= '0;
      restore_vin_q <= '0;
      wdata_q       <= '0;
      addr_q        <= '0;
      wr_en_q       <= 1'b0;
      rd_en_q       <= 1'b0;
      stand_by_q    <= 1'b0;
      done_q        <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      rst_drty_q   <= '0;
      restore_en_q <= '0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus_io.Bkp_req) begin
            // Invalidate the marker first so a torn backup is never restored
            state_q    <= StBkInv;
            stand_by_q <= 1'b1;
            wr_en_q    <= 1'b1;
            addr_q     <= MarkAddr;
            wdata_q    <= '0;
          end else if (bus_io.Rstr_req) begin
            state_q    <= StRsChk;
            stand_by_q <= 1'b1;
            rd_en_q    <= 1'b1;
            addr_q     <= MarkAddr;
          end
        end
        StBkInv: begin
          if (bus_io.nvm_ack) begin
            wr_en_q <= 1'b0;
            idx_q   <= '0;
            state_q <= StBkScan;
          end
        end
        StBkScan: begin
          if (idx_q == MarkAddr) begin
            state_q <= StBkMark;
            wr_en_q <= 1'b1;
            addr_q  <= MarkAddr;
            wdata_q <= MarkerW;
          end else if (dirty_sel) begin
            state_q     <= StBkReq;
            backup_en_q <= idx_oh;
          end else begin
            idx_q <= idx_q + IdxOne;
          end
        end
        StBkReq: begin
          if (ack_sel) begin
            backup_en_q <= '0;
            wdata_q     <= vout_sel;
            wr_en_q     <= 1'b1;
            addr_q      <= idx_q;
            state_q     <= StBkWr;
          end
        end
        StBkWr: begin
          if (bus_io.nvm_ack) begin
            wr_en_q    <= 1'b0;
            rst_drty_q <= idx_oh;
            idx_q      <= idx_q + IdxOne;
            state_q    <= StBkScan;
          end
        end
        StBkMark: begin
          if (bus_io.nvm_ack) begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StRsChk: begin
          if (bus_io.nvm_ack) begin
            if (bus_io.nvm_rdata == MarkerW) begin
              // Read request stays asserted and moves straight on to register 0
              idx_q   <= '0;
              addr_q  <= '0;
              state_q <= StRsRd;
            end else begin
              rd_en_q    <= 1'b0;
              fail_q     <= 1'b1;
              stand_by_q <= 1'b0;
              state_q    <= StIdle;
            end
          end
        end
        StRsRd: begin
          if (bus_io.nvm_ack) begin
            rd_en_q       <= 1'b0;
            restore_vin_q <= bus_io.nvm_rdata;
            restore_en_q  <= idx_oh;
            state_q       <= StRsWr;
          end
        end
        StRsWr: begin
          if (idx_q == LastIdx) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            idx_q   <= idx_q + IdxOne;
            addr_q  <= idx_q + IdxOne;
            rd_en_q <= 1'b1;
            state_q <= StRsRd;
          end
        end
        StDone: begin
          stand_by_q <= 1'b0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.Backup_en    = backup_en_q;
  assign bus_io.Rst_DrtyCtrl = rst_drty_q;
  assign bus_io.Restore_en   = restore_en_q;
  assign bus_io.Restore_Vin  = restore_vin_q;
  assign bus_io.nvm_wr_en    = wr_en_q;
  assign bus_io.nvm_rd_en    = rd_en_q;
  assign bus_io.nvm_addr     = addr_q;
  assign bus_io.nvm_wdata    = wdata_q;
  assign bus_io.stand_by     = stand_by_q;
  assign bus_io.Done         = done_q;
  assign bus_io.Rstr_fail    = fail_q;

endmodule

// File: tb/tb_backup_restore_ctrl.sv
// Bench for backup_restore_ctrl: register/NVM responders, event logs and a transaction-level
// reference model of the backup and restore sequences.
module tb_backup_restore_ctrl;
  localparam int unsigned NR = 8;
  localparam int unsigned W  = 32;
  localparam int unsigned AW = 4;
  localparam logic [31:0] MK = 32'hA5A55A5A;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  backup_restore_ctrl_if #(.NUM_REGS(NR), .WIDTH(W), .ADDR_W(AW)) bus ();

  backup_restore_ctrl #(.NUM_REGS(NR), .WIDTH(W), .ADDR_W(AW), .MARKER(MK)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .bus_io(bus)
  );

  logic [W-1:0]  regv    [NR];
  logic [NR-1:0] dirty;
  logic [W-1:0]  nvm     [NR+1];
  logic [W-1:0]  pre_mem [NR+1];
  logic [W-1:0]  ref_mem [NR+1];
  int unsigned   preload_seq = 0;
  int unsigned   bk_lat = 1, nvm_lat = 2;
  bit            spurious = 1'b0;

  int n_cmp = 0, n_err = 0;
  int unsigned viol_nvm = 0, viol_bk = 0, viol_mon = 0, stab_nvm = 0, stab_bk = 0;
  int unsigned done_cnt = 0, fail_cnt = 0;
  logic [63:0] wr_log[$], rd_log[$], clr_log[$], rs_log[$];
  logic [63:0] exp_wr[$], exp_rd[$], exp_clr[$], exp_rs[$];
  int unsigned exp_done, exp_fail;
  int unsigned b_wr, b_rd, b_clr, b_rs, b_done, b_fail, b_viol, b_stab;

  always_comb begin
    bus.Backup_Vout = '0;
    for (int i = 0; i < NR; i++) bus.Backup_Vout[i*W +: W] = regv[i];
  end
  assign bus.Dirty_val = dirty;

  // NVM device: fixed latency per request, checks the request is held stable until ack
  initial begin : nvm_resp
    int unsigned seen, cnt;
    bit pend, wr0;
    logic [AW-1:0] a0;
    logic [W-1:0] d0;
    seen = 0; cnt = 0; pend = 1'b0; wr0 = 1'b0; a0 = '0; d0 = '0;
    bus.nvm_ack = 1'b0;
    bus.nvm_rdata = '0;
    for (int i = 0; i <= NR; i++) nvm[i] = '0;
    forever begin
      @(negedge Clk);
      bus.nvm_ack = 1'b0;
      if (preload_seq != seen) begin
        for (int i = 0; i <= NR; i++) nvm[i] = pre_mem[i];
        seen = preload_seq;
      end
      if (bus.nvm_wr_en && bus.nvm_rd_en) viol_nvm++;
      if (Rst || !(bus.nvm_wr_en || bus.nvm_rd_en)) begin
        pend = 1'b0;
      end else begin
        if (!pend) begin
          pend = 1'b1; cnt = nvm_lat; a0 = bus.nvm_addr; d0 = bus.nvm_wdata; wr0 = bus.nvm_wr_en;
        end else if (bus.nvm_addr !== a0 || bus.nvm_wr_en !== wr0 ||
                     (wr0 && bus.nvm_wdata !== d0)) begin
          stab_nvm++;
        end
        if (cnt == 0) begin
          bus.nvm_ack = 1'b1;
          pend = 1'b0;
          if (wr0) begin
            nvm[a0] = d0;
            wr_log.push_back({32'(a0), d0});
          end else begin
            bus.nvm_rdata = nvm[a0];
            rd_log.push_back(64'(a0));
          end
        end else begin
          cnt--;
        end
      end
    end
  end

  // Register wrappers: acknowledge Backup_en after bk_lat cycles, optionally with noise bits
  initial begin : bk_resp
    int unsigned cnt;
    bit pend;
    logic [NR-1:0] en0;
    cnt = 0; pend = 1'b0; en0 = '0;
    bus.Backup_ack = '0;
    forever begin
      @(negedge Clk);
      bus.Backup_ack = '0;
      if (Rst || bus.Backup_en == '0) begin
        pend = 1'b0;
      end else begin
        if ($countones(bus.Backup_en) != 1) viol_bk++;
        if (!pend) begin
          pend = 1'b1; cnt = bk_lat; en0 = bus.Backup_en;
        end else if (bus.Backup_en !== en0) begin
          stab_bk++;
        end
        if (cnt == 0) begin
          bus.Backup_ack = bus.Backup_en;
          pend = 1'b0;
        end else begin
          cnt--;
          if (spurious) bus.Backup_ack = ~bus.Backup_en;
        end
      end
    end
  end

  initial begin : mon
    forever begin
      @(negedge Clk);
      if (!Rst) begin
        if ($countones(bus.Rst_DrtyCtrl) > 1 || $countones(bus.Restore_en) > 1) viol_mon++;
        if (bus.Rst_DrtyCtrl != '0) clr_log.push_back(64'(bus.Rst_DrtyCtrl));
        if (bus.Restore_en != '0) rs_log.push_back({32'(bus.Restore_en), bus.Restore_Vin});
        if (bus.Done) done_cnt++;
        if (bus.Rstr_fail) fail_cnt++;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snapshot();
    b_wr = wr_log.size(); b_rd = rd_log.size(); b_clr = clr_log.size(); b_rs = rs_log.size();
    b_done = done_cnt; b_fail = fail_cnt;
    b_viol = viol_nvm + viol_bk + viol_mon; b_stab = stab_nvm + stab_bk;
    exp_wr.delete(); exp_rd.delete(); exp_clr.delete(); exp_rs.delete();
    exp_done = 0; exp_fail = 0;
  endtask

  function automatic int unsigned obs_size(input int sel);
    case (sel)
      0: return wr_log.size() - b_wr;
      1: return rd_log.size() - b_rd;
      2: return clr_log.size() - b_clr;
      default: return rs_log.size() - b_rs;
    endcase
  endfunction

  function automatic logic [63:0] obs_at(input int sel, input int i);
    case (sel)
      0: return wr_log[b_wr + i];
      1: return rd_log[b_rd + i];
      2: return clr_log[b_clr + i];
      default: return rs_log[b_rs + i];
    endcase
  endfunction

  function automatic int unsigned exp_size(input int sel);
    case (sel)
      0: return exp_wr.size();
      1: return exp_rd.size();
      2: return exp_clr.size();
      default: return exp_rs.size();
    endcase
  endfunction

  function automatic logic [63:0] exp_at(input int sel, input int i);
    case (sel)
      0: return exp_wr[i];
      1: return exp_rd[i];
      2: return exp_clr[i];
      default: return exp_rs[i];
    endcase
  endfunction

  // Reference: a backup is invalidate, then each dirty register in index order, then marker
  task automatic model_backup(input logic [NR-1:0] d);
    exp_wr.push_back({32'(NR), 32'h0});
    ref_mem[NR] = '0;
    for (int i = 0; i < NR; i++) begin
      if (d[i]) begin
        exp_wr.push_back({32'(i), regv[i]});
        exp_clr.push_back(64'(1) << i);
        ref_mem[i] = regv[i];
      end
    end
    exp_wr.push_back({32'(NR), MK});
    ref_mem[NR] = MK;
    exp_done = 1;
  endtask

  task automatic model_restore();
    exp_rd.push_back(64'(NR));
    if (ref_mem[NR] == MK) begin
      for (int i = 0; i < NR; i++) begin
        exp_rd.push_back(64'(i));
        exp_rs.push_back({32'(1) << i, ref_mem[i]});
      end
      exp_done = 1;
    end else begin
      exp_fail = 1;
    end
  endtask

  task automatic wait_end(input int budget, input bit toggle, output bit ended,
                          output int sb_bad);
    ended = 1'b0; sb_bad = 0;
    for (int c = 0; c < budget && !ended; c++) begin
      @(negedge Clk);
      bus.Bkp_req = 1'b0;
      bus.Rstr_req = toggle ? 1'($urandom) : 1'b0;
      if (bus.Done || bus.Rstr_fail) begin
        ended = 1'b1;
        bus.Rstr_req = 1'b0;
        if (bus.Done && !bus.stand_by) sb_bad++;
      end else if (!bus.stand_by) begin
        sb_bad++;
      end
    end
    bus.Bkp_req = 1'b0;
    bus.Rstr_req = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic compare_logs(input string tag, input bit ended, input int sb_bad);
    string nm [4];
    nm[0] = "wr"; nm[1] = "rd"; nm[2] = "clr"; nm[3] = "rs";
    check({tag, "_end"}, 64'(ended), 64'd1);
    check({tag, "_standby"}, 64'(sb_bad), 64'd0);
    for (int s = 0; s < 4; s++) begin
      check($sformatf("%s_%s_count", tag, nm[s]), 64'(obs_size(s)), 64'(exp_size(s)));
      for (int i = 0; i < int'(exp_size(s)) && i < int'(obs_size(s)); i++)
        check($sformatf("%s_%s_%0d", tag, nm[s], i), obs_at(s, i), exp_at(s, i));
    end
    check({tag, "_done"}, 64'(done_cnt - b_done), 64'(exp_done));
    check({tag, "_rstr_fail"}, 64'(fail_cnt - b_fail), 64'(exp_fail));
    check({tag, "_onehot"}, 64'(viol_nvm + viol_bk + viol_mon - b_viol), 64'd0);
    check({tag, "_held"}, 64'(stab_nvm + stab_bk - b_stab), 64'd0);
    check({tag, "_idle_after"}, 64'({bus.stand_by, bus.nvm_wr_en, bus.nvm_rd_en}), 64'd0);
  endtask

  task automatic run_backup(input string tag, input logic [NR-1:0] d, input bit with_rstr);
    bit ended;
    int sb_bad;
    snapshot();
    dirty = d;
    model_backup(d);
    bus.Bkp_req = 1'b1;
    bus.Rstr_req = with_rstr;
    wait_end(6000, with_rstr, ended, sb_bad);
    compare_logs(tag, ended, sb_bad);
  endtask

  task automatic run_restore(input string tag);
    bit ended;
    int sb_bad;
    snapshot();
    model_restore();
    bus.Rstr_req = 1'b1;
    wait_end(6000, 1'b0, ended, sb_bad);
    compare_logs(tag, ended, sb_bad);
  endtask

  task automatic preload(input logic [W-1:0] marker);
    for (int i = 0; i < NR; i++) begin
      pre_mem[i] = W'(i * 32'h11);
      ref_mem[i] = W'(i * 32'h11);
    end
    pre_mem[NR] = marker;
    ref_mem[NR] = marker;
    preload_seq++;
    repeat (2) @(negedge Clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_standby"}, 64'(bus.stand_by), 64'd0);
    check({tag, "_pulses"}, {32'(bus.nvm_addr), 29'd0, bus.Done, bus.Rstr_fail,
                             bus.nvm_wr_en | bus.nvm_rd_en}, 64'd0);
    check({tag, "_strobes"}, {40'd0, bus.Backup_en, bus.Rst_DrtyCtrl, bus.Restore_en}, 64'd0);
    check({tag, "_data"}, {bus.nvm_wdata, bus.Restore_Vin}, 64'd0);
  endtask

  initial begin : main
    logic [NR-1:0] d;
    bit found;
    Rst = 1'b1;
    bus.Bkp_req = 1'b0;
    bus.Rstr_req = 1'b0;
    dirty = '0;
    for (int i = 0; i < NR; i++) regv[i] = $urandom;
    for (int i = 0; i <= NR; i++) begin
      ref_mem[i] = '0;
      pre_mem[i] = '0;
    end
    repeat (3) @(negedge Clk);
    check_quiet("reset");
    Rst = 1'b0;
    repeat (2) @(negedge Clk);
    check_quiet("post_reset");

    bk_lat = 1; nvm_lat = 2;
    run_backup("bk_partial", 8'b0010_0101, 1'b0);

    preload(MK);
    run_restore("rs_valid");
    preload('0);
    run_restore("rs_invalid");

    // Reset while register 2 is being written to NVM
    for (int i = 0; i < NR; i++) regv[i] = $urandom;
    d = NR'($urandom) | 8'h04;
    snapshot();
    dirty = d;
    exp_wr.push_back({32'(NR), 32'h0});
    ref_mem[NR] = '0;
    for (int i = 0; i < 2; i++) begin
      if (d[i]) begin
        exp_wr.push_back({32'(i), regv[i]});
        exp_clr.push_back(64'(1) << i);
        ref_mem[i] = regv[i];
      end
    end
    bus.Bkp_req = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      @(negedge Clk);
      bus.Bkp_req = 1'b0;
      if (bus.nvm_wr_en && bus.nvm_addr == AW'(2)) found = 1'b1;
    end
    #2 Rst = 1'b1;
    #1 check_quiet("mid_reset");
    @(negedge Clk);
    Rst = 1'b0;
    repeat (2) @(negedge Clk);
    compare_logs("mid_reset", found, 0);
    run_restore("rs_after_reset");

    run_backup("prio", NR'($urandom), 1'b1);
    run_backup("zero_dirty", '0, 1'b1);

    bk_lat = 20; nvm_lat = 15; spurious = 1'b1;
    for (int i = 0; i < NR; i++) regv[i] = $urandom;
    run_backup("slow", NR'($urandom) | 8'h81, 1'b0);
    run_restore("slow_rs");

    for (int r = 0; r < 6; r++) begin
      bk_lat = $urandom_range(0, 4);
      nvm_lat = $urandom_range(0, 4);
      spurious = 1'($urandom);
      for (int i = 0; i < NR; i++) regv[i] = $urandom;
      run_backup($sformatf("rnd%0d_bk", r), NR'($urandom), 1'($urandom));
      run_restore($sformatf("rnd%0d_rs", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
